// File: rtl/hps_pio_bank.sv
// Multi-channel Avalon-MM PIO bank: per-channel DATA/SET/CLR outputs, synchronised input readback.
// Define HPS_PIO_BANK_EDGE_IRQ_EN to add per-channel EDGE/MASK registers and level interrupts.
module hps_pio_bank #(
  parameter int                DATA_W    = 32,
  parameter int                N_CH      = 4,
  parameter logic [DATA_W-1:0] RESET_VAL = '0,
  localparam int               ADDR_W    = $clog2(N_CH) + 3
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [ADDR_W-1:0]        address,
  input  logic                     chipselect,
  input  logic                     write_n,
  input  logic                     read_n,
  input  logic [31:0]              writedata,
  output logic [31:0]              readdata,
  output logic                     readdatavalid,
  output logic [N_CH*DATA_W-1:0]   out_port,
  output logic [N_CH-1:0]          out_update,
  input  logic [N_CH*DATA_W-1:0]   in_port,
  output logic [N_CH-1:0]          irq
);

  logic              wr, rd;
  logic [ADDR_W-1:0] ch_sel;
  logic [2:0]        word;
  logic [DATA_W-1:0] wd;
  logic [N_CH-1:0]   ch_hit;
  logic [DATA_W-1:0] rd_mux;

  logic [DATA_W-1:0] out_reg [N_CH];
  logic [DATA_W-1:0] sync1   [N_CH];
  logic [DATA_W-1:0] sync2   [N_CH];

  assign wr     = chipselect & ~write_n;
  assign rd     = chipselect & ~read_n;
  assign ch_sel = address >> 3;
  assign word   = address[2:0];
  assign wd     = writedata[DATA_W-1:0];

  // Out-of-range channel indices match no channel, so they read 0 and write nothing.
  always_comb begin
    ch_hit = '0;
    for (int c = 0; c < N_CH; c++)
      ch_hit[c] = (ch_sel == ADDR_W'(c));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int c = 0; c < N_CH; c++) out_reg[c] <= RESET_VAL;
      out_update <= '0;
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        out_update[c] <= wr && ch_hit[c] && (word < 3'd3);
        if (wr && ch_hit[c]) begin
          case (word)
            3'd0:    out_reg[c] <= wd;
            3'd1:    out_reg[c] <= out_reg[c] | wd;
            3'd2:    out_reg[c] <= out_reg[c] & ~wd;
            default: out_reg[c] <= out_reg[c];
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int c = 0; c < N_CH; c++) begin
        sync1[c] <= '0;
        sync2[c] <= '0;
      end
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        sync1[c] <= in_port[c*DATA_W +: DATA_W];
        sync2[c] <= sync1[c];
      end
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_out
    assign out_port[g*DATA_W +: DATA_W] = out_reg[g];
  end

`ifdef HPS_PIO_BANK_EDGE_IRQ_EN
  logic [DATA_W-1:0] sync3    [N_CH];
  logic [DATA_W-1:0] edge_reg [N_CH];
  logic [DATA_W-1:0] mask_reg [N_CH];

  // A new rising edge overrides a same-cycle write-1-to-clear on the same bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int c = 0; c < N_CH; c++) begin
        sync3[c]    <= '0;
        edge_reg[c] <= '0;
        mask_reg[c] <= '0;
      end
      irq <= '0;
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        sync3[c]    <= sync2[c];
        edge_reg[c] <= (edge_reg[c] & ~((wr && ch_hit[c] && word == 3'd4) ? wd : '0))
                       | (sync2[c] & ~sync3[c]);
        if (wr && ch_hit[c] && word == 3'd5) mask_reg[c] <= wd;
        irq[c] <= |(edge_reg[c] & mask_reg[c]);
      end
    end
  end
`else
  assign irq = '0;
`endif

  always_comb begin
    rd_mux = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (ch_hit[c]) begin
        case (word)
          3'd0:    rd_mux = out_reg[c];
          3'd3:    rd_mux = sync2[c];
`ifdef HPS_PIO_BANK_EDGE_IRQ_EN
          3'd4:    rd_mux = edge_reg[c];
          3'd5:    rd_mux = mask_reg[c];
`endif
          default: rd_mux = '0;
        endcase
      end
    end
  end

  // Read mux sees pre-edge register values, so a same-cycle write is not visible.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata      <= '0;
      readdatavalid <= 1'b0;
    end else begin
      readdatavalid <= rd;
      if (rd) readdata <= 32'(rd_mux);
    end
  end

endmodule

// File: tb/tb_hps_pio_bank.sv
// Directed self-checking bench for hps_pio_bank (N_CH=5 so out-of-range channels 5..7 exist).
module tb_hps_pio_bank;
  localparam int DW = 32;
  localparam int NC = 5;
  localparam int AW = $clog2(NC) + 3;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic [AW-1:0]   address = '0;
  logic            chipselect = 1'b0, write_n = 1'b1, read_n = 1'b1;
  logic [31:0]     writedata = '0;
  logic [31:0]     readdata;
  logic            readdatavalid;
  logic [NC*DW-1:0] out_port;
  logic [NC-1:0]   out_update;
  logic [NC*DW-1:0] in_port = '0;
  logic [NC-1:0]   irq;

  int checks = 0;
  int errors = 0;

  hps_pio_bank #(.DATA_W(DW), .N_CH(NC), .RESET_VAL(32'hA5)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .read_n(read_n), .writedata(writedata), .readdata(readdata),
    .readdatavalid(readdatavalid), .out_port(out_port), .out_update(out_update),
    .in_port(in_port), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [NC*DW-1:0] obs, input logic [NC*DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic bus(input int ch, input int w, input logic [31:0] d, input logic do_wr, input logic do_rd);
    address    = AW'(ch * 8 + w);
    writedata  = d;
    chipselect = 1'b1;
    write_n    = ~do_wr;
    read_n     = ~do_rd;
  endtask

  task automatic idle();
    chipselect = 1'b0;
    write_n    = 1'b1;
    read_n     = 1'b1;
  endtask

  function automatic logic [31:0] och(input int c);
    return out_port[c*DW +: DW];
  endfunction

  initial begin
    in_port[1*DW +: DW] = 32'h1111_1111;
    #12;
    chk("reset_out_port", out_port, {NC{32'h0000_00A5}});
    chk("reset_rdv", 160'(readdatavalid), '0);
    chk("reset_irq", 160'(irq), '0);
    chk("reset_out_update", 160'(out_update), '0);
    @(negedge clk); reset_n = 1'b1;
    @(negedge clk);

    // DATA / SET / CLR on ch2, back-to-back
    bus(2, 0, 32'h1234_5678, 1, 0);
    @(negedge clk);
    chk("data_ch2", 160'(och(2)), 160'(32'h1234_5678));
    chk("upd_data", 160'(out_update), 160'(5'b00100));
    bus(2, 1, 32'h0000_000F, 1, 0);
    @(negedge clk);
    chk("set_ch2", 160'(och(2)), 160'(32'h1234_567F));
    chk("upd_set", 160'(out_update), 160'(5'b00100));
    bus(2, 2, 32'h0000_0070, 1, 0);
    @(negedge clk);
    chk("clr_ch2", 160'(och(2)), 160'(32'h1234_560F));
    chk("upd_clr", 160'(out_update), 160'(5'b00100));
    idle();
    @(negedge clk);
    chk("upd_idle", 160'(out_update), '0);
    chk("others_untouched", out_port, {32'hA5, 32'hA5, 32'h1234_560F, 32'hA5, 32'hA5});

    // Input synchroniser latency on ch1
    in_port[1*DW +: DW] = 32'hDEAD_BEEF;
    @(negedge clk);
    bus(1, 3, '0, 0, 1);
    @(negedge clk);
    chk("in_early_old", 160'(readdata), 160'(32'h1111_1111));
    chk("in_early_rdv", 160'(readdatavalid), 160'(1'b1));
    bus(1, 3, '0, 0, 1);
    @(negedge clk);
    chk("in_sync", 160'(readdata), 160'(32'hDEAD_BEEF));
    chk("in_sync_rdv", 160'(readdatavalid), 160'(1'b1));
    idle();
    @(negedge clk);
    chk("rdv_drop", 160'(readdatavalid), '0);
    chk("rd_hold", 160'(readdata), 160'(32'hDEAD_BEEF));

    // Same-cycle read and write of DATA ch0
    bus(0, 0, 32'h1, 1, 0);
    @(negedge clk);
    bus(0, 0, 32'h2, 1, 1);
    @(negedge clk);
    chk("rw_pre_value", 160'(readdata), 160'(32'h1));
    chk("rw_out_ch0", 160'(och(0)), 160'(32'h2));
    bus(0, 0, '0, 0, 1);
    @(negedge clk);
    chk("rw_post_value", 160'(readdata), 160'(32'h2));

    // Out-of-range channel and zero-reading words
    bus(5, 0, 32'hFFFF_FFFF, 1, 1);
    @(negedge clk);
    chk("oor_read", 160'(readdata), '0);
    chk("oor_rdv", 160'(readdatavalid), 160'(1'b1));
    chk("oor_upd", 160'(out_update), '0);
    chk("oor_no_write", out_port, {32'hA5, 32'hA5, 32'h1234_560F, 32'hA5, 32'h2});
    bus(2, 0, '0, 0, 1);
    @(negedge clk);
    bus(2, 1, '0, 0, 1);
    @(negedge clk);
    chk("set_reads_0", 160'(readdata), '0);
    bus(2, 0, '0, 0, 1);
    @(negedge clk);
    bus(2, 6, '0, 0, 1);
    @(negedge clk);
    chk("rsvd_reads_0", 160'(readdata), '0);
    bus(2, 3, 32'h0, 1, 0);
    @(negedge clk);
    chk("in_write_ignored", 160'(och(2)), 160'(32'h1234_560F));
    chk("in_write_no_upd", 160'(out_update), '0);
    idle();

`ifdef HPS_PIO_BANK_EDGE_IRQ_EN
    bus(3, 5, 32'h1, 1, 0);
    @(negedge clk);
    bus(3, 5, '0, 0, 1);
    @(negedge clk);
    chk("mask_read", 160'(readdata), 160'(32'h1));
    idle();
    in_port[3*DW] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("irq_not_yet", 160'(irq), '0);
    @(negedge clk);
    chk("irq_cycle4", 160'(irq), 160'(5'b01000));
    bus(3, 4, '0, 0, 1);
    @(negedge clk);
    chk("edge_read", 160'(readdata), 160'(32'h1));
    bus(3, 4, 32'h1, 1, 0);
    @(negedge clk);
    idle();
    chk("irq_lag", 160'(irq), 160'(5'b01000));
    @(negedge clk);
    chk("irq_cleared", 160'(irq), '0);
    in_port[3*DW] = 1'b0;
    repeat (4) @(negedge clk);
    in_port[3*DW] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    bus(3, 4, 32'h1, 1, 0);
    @(negedge clk);
    bus(3, 4, '0, 0, 1);
    @(negedge clk);
    chk("edge_beats_clear", 160'(readdata), 160'(32'h1));
    idle();
`else
    bus(3, 5, 32'h1, 1, 0);
    @(negedge clk);
    bus(3, 0, '0, 0, 1);
    @(negedge clk);
    bus(3, 5, '0, 0, 1);
    @(negedge clk);
    chk("mask_reads_0", 160'(readdata), '0);
    in_port[3*DW] = 1'b1;
    bus(3, 0, '0, 0, 1);
    repeat (5) @(negedge clk);
    bus(3, 4, '0, 0, 1);
    @(negedge clk);
    chk("edge_reads_0", 160'(readdata), '0);
    chk("irq_tied_0", 160'(irq), '0);
    idle();
`endif

    // Reset during a read
    @(negedge clk);
    bus(1, 3, '0, 0, 1);
    #3 reset_n = 1'b0;
    #1;
    chk("async_reset_out", out_port, {NC{32'h0000_00A5}});
    @(posedge clk); #1;
    chk("reset_rdv_dropped", 160'(readdatavalid), '0);
    @(negedge clk);
    chk("reset_rd_cleared", 160'(readdata), '0);
    idle();
    @(negedge clk);
    reset_n = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
